// File: rtl/autosym_eval_pipe.sv
// autosym_eval_pipe: two-stage pipelined evaluator of f(x) = g(A.x) over GF(2) with run-time programmable A and g.
// Build option ASYM_SHADOW_EN: shadow matrix/table bank exchanged by cfg_swap instead of the RUN/DRAIN/CFG stall.
module autosym_eval_pipe #(
    parameter int unsigned N    = 10,
    parameter int unsigned K    = 6,
    parameter int unsigned OUTS = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N-1:0]                       x,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUTS-1:0]                    y,
    input  logic                               cfg_we,
    input  logic                               cfg_sel,
    input  logic [K-1:0]                       cfg_addr,
    input  logic [((N > OUTS) ? N : OUTS)-1:0] cfg_wdata,
`ifdef ASYM_SHADOW_EN
    input  logic                               cfg_swap,
`endif
    output logic                               cfg_busy
);
    localparam int unsigned W     = (N > OUTS) ? N : OUTS;
    localparam int unsigned DEPTH = 1 << K;

    logic            live;
    logic            run_ok;
    logic            s1_valid;
    logic [K-1:0]    s1_z;
    logic            s1_load;
    logic            s2_load;
    logic [K-1:0]    z_c;
    logic [OUTS-1:0] lut_c;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = live && run_ok && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;

    // live keeps in_ready low while rst is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    // S1: projected vector z = A.x
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_z     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_z     <= z_c;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: table lookup, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            y         <= lut_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ASYM_SHADOW_EN
    logic            bank;
    logic            s1_bank;
    logic [N-1:0]    a_mat [2][K];
    logic [OUTS-1:0] tbl   [2][DEPTH];

    assign run_ok   = 1'b1;
    assign cfg_busy = 1'b0;
    assign lut_c    = tbl[s1_bank][s1_z];

    always_comb begin
        z_c = '0;
        for (int i = 0; i < K; i++) z_c[i] = ^(a_mat[bank][i] & x);
    end

    // bank tag travels with each S1 entry so the lookup matches its projection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank    <= 1'b0;
            s1_bank <= 1'b0;
        end else begin
            if (s1_load)  s1_bank <= bank;
            if (cfg_swap) bank    <= ~bank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < K; i++)     a_mat[b][i] <= N'(1) << i;
                for (int j = 0; j < DEPTH; j++) tbl[b][j]   <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_sel) begin
                tbl[~bank][cfg_addr] <= cfg_wdata[OUTS-1:0];
            end else begin
                for (int i = 0; i < K; i++)
                    if (cfg_addr == K'(i)) a_mat[~bank][i] <= cfg_wdata[N-1:0];
            end
        end
    end
`else
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CFG = 2'd2} state_t;
    typedef struct packed {
        logic         sel;
        logic [K-1:0] addr;
        logic [W-1:0] data;
    } cfg_wr_t;

    state_t          state;
    state_t          state_next;
    cfg_wr_t         pend;
    cfg_wr_t         pend_next;
    cfg_wr_t         cur_c;
    cfg_wr_t         wr_c;
    logic            wr_en_c;
    logic            idle;
    logic            idle_next;
    logic [N-1:0]    a_mat [K];
    logic [OUTS-1:0] tbl   [DEPTH];

    assign run_ok = (state == RUN);
    assign cur_c  = {cfg_sel, cfg_addr, cfg_wdata};
    assign lut_c  = tbl[s1_z];

    always_comb begin
        z_c = '0;
        for (int i = 0; i < K; i++) z_c[i] = ^(a_mat[i] & x);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pend     <= '0;
            idle     <= 1'b0;
            cfg_busy <= 1'b0;
        end else begin
            state    <= state_next;
            pend     <= pend_next;
            idle     <= idle_next;
            cfg_busy <= (state_next != RUN);
        end
    end

    // idle marks one write-free CFG cycle; a second one closes the window
    always_comb begin
        state_next = state;
        pend_next  = pend;
        idle_next  = 1'b0;
        wr_en_c    = 1'b0;
        wr_c       = cur_c;
        case (state)
            RUN: begin
                if (cfg_we) begin
                    state_next = DRAIN;
                    pend_next  = cur_c;
                end
            end
            DRAIN: begin
                if (cfg_we) pend_next = cur_c;
                if (!s1_valid && !out_valid) begin
                    state_next = CFG;
                    wr_en_c    = 1'b1;
                    wr_c       = pend_next;
                end
            end
            CFG: begin
                if (cfg_we)    wr_en_c    = 1'b1;
                else if (idle) state_next = RUN;
                else           idle_next  = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++)     a_mat[i] <= N'(1) << i;
            for (int j = 0; j < DEPTH; j++) tbl[j]   <= '0;
        end else if (wr_en_c) begin
            if (wr_c.sel) begin
                tbl[wr_c.addr] <= wr_c.data[OUTS-1:0];
            end else begin
                for (int i = 0; i < K; i++)
                    if (wr_c.addr == K'(i)) a_mat[i] <= wr_c.data[N-1:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_autosym_eval_pipe.sv
// tb_autosym_eval_pipe: randomized self-checking bench for autosym_eval_pipe against a GF(2) parity model.
// Compile both files with ASYM_SHADOW_EN defined to exercise the shadow-bank build.
`timescale 1ns/1ps
module tb_autosym_eval_pipe;
    localparam int unsigned N     = 10;
    localparam int unsigned K     = 6;
    localparam int unsigned OUTS  = 1;
    localparam int unsigned W     = 10;
    localparam int unsigned DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    x;
    logic            out_valid;
    logic            out_ready;
    logic [OUTS-1:0] y;
    logic            cfg_we;
    logic            cfg_sel;
    logic [K-1:0]    cfg_addr;
    logic [W-1:0]    cfg_wdata;
    logic            cfg_busy;
    logic            cfg_swap;

    autosym_eval_pipe #(.N(N), .K(K), .OUTS(OUTS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
`ifdef ASYM_SHADOW_EN
        .cfg_swap  (cfg_swap),
`endif
        .cfg_busy  (cfg_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sel;
        logic [K-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_n = 0;
    int n_out = 0;
    int last_out_cyc = 0;

    logic [N-1:0]    m_a [2][K];
    logic [OUTS-1:0] m_t [2][DEPTH];
    logic            m_bank;
    logic [OUTS-1:0] exp_q [$];
    wr_t             wq [$];
    logic            hold_v = 1'b0;
    logic [OUTS-1:0] hold_y = '0;
    logic [N-1:0]    rows [K];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // f(x) = T[z], z[i] = parity of (row i AND x)
    function automatic logic [OUTS-1:0] model_f(input logic [N-1:0] xv);
        logic [K-1:0] z;
        z = '0;
        for (int i = 0; i < K; i++) z[i] = (($countones(m_a[m_bank][i] & xv) % 2) == 1);
        return m_t[m_bank][z];
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < K; i++)     m_a[b][i] = N'(1) << i;
            for (int j = 0; j < DEPTH; j++) m_t[b][j] = '0;
        end
        m_bank = 1'b0;
    endfunction

    function automatic void model_write(input logic sel, input logic [K-1:0] addr, input logic [W-1:0] data);
        logic wb;
`ifdef ASYM_SHADOW_EN
        wb = ~m_bank;
`else
        wb = m_bank;
`endif
        if (sel) m_t[wb][addr] = data[OUTS-1:0];
        else if (int'(addr) < K) m_a[wb][int'(addr)] = data[N-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_y", 32'(y), 32'(hold_y));
            end
            if (cfg_busy) begin
                busy_n++;
                check("busy_in_ready", 32'(in_ready), 32'd0);
            end
            if (in_valid && in_ready) exp_q.push_back(model_f(x));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 32'(out_valid), 32'd0);
                end else begin
                    check("y", 32'(y), 32'(exp_q.pop_front()));
                    n_out++;
                    last_out_cyc = cyc;
                end
            end
            if (cfg_we) model_write(cfg_sel, cfg_addr, cfg_wdata);
`ifdef ASYM_SHADOW_EN
            if (cfg_swap) m_bank = ~m_bank;
`endif
            hold_v = out_valid && !out_ready;
            hold_y = y;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 200) begin
            tick();
            k++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (cfg_busy && k < 200) begin
            tick();
            k++;
        end
        check("busy_timeout", 32'(cfg_busy), 32'd0);
    endtask

    task automatic rand_traffic(input int cycles, input bit bp);
        for (int c = 0; c < cycles; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            x         = N'($urandom);
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_empty();
    endtask

    // first queued write opens the window; the rest follow once drain cycles have passed
    task automatic cfg_burst(input int drain, input bit with_x, input logic [N-1:0] xv);
        wr_t w;
        w = wq.pop_front();
        cfg_we = 1'b1;
        {cfg_sel, cfg_addr, cfg_wdata} = w;
        if (with_x) begin
            in_valid = 1'b1;
            x        = xv;
        end
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        repeat (drain) tick();
        while (wq.size() != 0) begin
            w = wq.pop_front();
            cfg_we = 1'b1;
            {cfg_sel, cfg_addr, cfg_wdata} = w;
            tick();
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int first_cyc;
        int base;

        rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_swap = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // latency with the reset configuration
        in_valid = 1'b1; x = 10'h3FF;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat1_out_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("lat2_out_valid", 32'(out_valid), 32'd1);
        check("lat2_y", 32'(y), 32'd0);
        tick();
        wait_empty();

`ifdef ASYM_SHADOW_EN
        // swap banks mid-stream without stalling
        stalls = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            x = N'($urandom);
            cfg_we = 1'b0; cfg_swap = 1'b0;
            if (c < 6) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = K'(c); cfg_wdata = W'($urandom);
            end else if (c < 20) begin
                cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = K'($urandom); cfg_wdata = W'(1);
            end
            if (c == 20) cfg_swap = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            check("shadow_cfg_busy", 32'(cfg_busy), 32'd0);
            tick();
        end
        in_valid = 1'b0; cfg_we = 1'b0; cfg_swap = 1'b0;
        wait_empty();
        check("shadow_stalls", 32'(stalls), 32'd0);
`else
        // program the plan's matrix and a parity table
        rows = '{10'h003, 10'h00C, 10'h030, 10'h0C0, 10'h300, 10'h001};
        busy_n = 0;
        for (int i = 0; i < K; i++) wq.push_back({1'b0, K'(i), rows[i]});
        wq.push_back({1'b0, K'(7), W'(10'h3FF)});
        for (int i = 0; i < DEPTH; i++) wq.push_back({1'b1, K'(i), W'($countones(i) % 2)});
        cfg_burst(1, 1'b0, '0);
        wait_not_busy();
        check("busy_len_prog", 32'(busy_n), 32'd73);

        // full sweep at one result per cycle
        stalls = 0; first_cyc = 0; base = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            x = N'(i);
            @(negedge clk);
            if (!in_ready) stalls++;
            if (i == 0) first_cyc = cyc;
            tick();
        end
        in_valid = 1'b0;
        wait_empty();
        check("sweep_count", 32'(n_out - base), 32'd1024);
        check("sweep_stalls", 32'(stalls), 32'd0);
        check("sweep_cycles", 32'(last_out_cyc - first_cyc + 1), 32'd1026);

        // reconfigure with two transactions in flight
        busy_n = 0;
        for (int i = 0; i < K; i++) wq.push_back({1'b0, K'(i), W'($urandom)});
        for (int i = 0; i < DEPTH; i++) wq.push_back({1'b1, K'(i), W'($urandom_range(0, 1))});
        in_valid = 1'b1; x = N'($urandom);
        tick();
        cfg_burst(3, 1'b1, N'($urandom));
        wait_not_busy();
        check("busy_len_inflight", 32'(busy_n), 32'd74);
        rand_traffic(200, 1'b0);
`endif

        // backpressure: consumer stalls for five cycles
        out_ready = 1'b0; in_valid = 1'b1; x = N'($urandom);
        for (int c = 0; c < 5; c++) begin
            logic acc;
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) x = N'($urandom);
        end
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_held", 32'(exp_q.size()), 32'd2);
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        wait_empty();
        rand_traffic(300, 1'b1);

        // reset between acceptance and output
        in_valid = 1'b1; x = N'($urandom);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        check("rerst_in_ready", 32'(in_ready), 32'd1);
        check("rerst_cfg_busy", 32'(cfg_busy), 32'd0);
        repeat (3) tick();
        in_valid = 1'b1; x = 10'h02A;
        tick();
        for (int c = 0; c < 16; c++) begin
            x = N'($urandom);
            tick();
        end
        in_valid = 1'b0;
        wait_empty();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
